// File: rtl/axi4_video_stream_monitor_if.sv
// AXI4-Stream video bundle: tuser marks start of frame, tlast marks end of line.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport mst (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slv (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axi4_video_stream_monitor.sv
// In-line AXI4-Stream video checker: 2-entry skid buffer pass-through plus
// line/frame geometry measurement, frame counting and sticky framing-error flags.
module axi4_video_stream_monitor #(
  parameter int TDATA_WIDTH = 32,
  parameter int X_ACTIVE    = 1920,
  parameter int Y_ACTIVE    = 1080,
  parameter int CNT_WIDTH   = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  axi4_stream_if.slv           video_i,
  axi4_stream_if.mst           video_o,
  input  logic                 clr_err_i,
  output logic [CNT_WIDTH-1:0] meas_width_o,
  output logic [CNT_WIDTH-1:0] meas_height_o,
  output logic [15:0]          frame_cnt_o,
  output logic                 err_early_eol_o,
  output logic                 err_late_eol_o,
  output logic                 err_early_sof_o,
  output logic                 err_missing_sof_o,
  output logic                 locked_o
);

  typedef enum logic [1:0] {WAIT_SOF, IN_FRAME, EXPECT_SOF} state_e;

  localparam int BeatW = TDATA_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] XLast  = CNT_WIDTH'(X_ACTIVE - 1);
  localparam logic [CNT_WIDTH-1:0] YLast  = CNT_WIDTH'(Y_ACTIVE - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [BeatW-1:0] mem_q [2];
  logic             wrPtr_q, rdPtr_q, inReady_q;
  logic [1:0]       fill_q, fill_d;
  logic             inBeat, outBeat;

  assign inBeat         = video_i.tvalid & inReady_q;
  assign outBeat        = video_o.tvalid & video_o.tready;
  assign video_i.tready = inReady_q;
  assign video_o.tvalid = (fill_q != 2'd0);
  assign {video_o.tdata, video_o.tlast, video_o.tuser} = mem_q[rdPtr_q];

  always_comb begin
    fill_d = fill_q;
    case ({inBeat, outBeat})
      2'b10:   fill_d = fill_q + 2'd1;
      2'b01:   fill_d = fill_q - 2'd1;
      default: fill_d = fill_q;
    endcase
  end

  // tready is the registered "not full" of the next occupancy, so it never combinationally depends on video_o.tready
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
      fill_q    <= 2'd0;
      inReady_q <= 1'b0;
    end else begin
      if (inBeat) begin
        mem_q[wrPtr_q] <= {video_i.tdata, video_i.tlast, video_i.tuser};
        wrPtr_q        <= ~wrPtr_q;
      end
      if (outBeat) rdPtr_q <= ~rdPtr_q;
      fill_q    <= fill_d;
      inReady_q <= (fill_d != 2'd2);
    end
  end

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] pxCnt_q, pxCnt_d, lnCnt_q, lnCnt_d;
  logic [CNT_WIDTH-1:0] measWidth_q, measWidth_d, measHeight_q, measHeight_d;
  logic [15:0]          frameCnt_q, frameCnt_d;
  logic                 errEarlyEol_q, errEarlyEol_d, errLateEol_q, errLateEol_d;
  logic                 errEarlySof_q, errEarlySof_d, errMissingSof_q, errMissingSof_d;
  logic                 locked_q, locked_d, dirty_q, dirty_d;
  logic [1:0]           cleanCnt_q, cleanCnt_d;
  logic                 startFrame, countBeat, newErr;
  logic [CNT_WIDTH-1:0] px, ln;

  always_comb begin
    state_d         = state_q;
    pxCnt_d         = pxCnt_q;
    lnCnt_d         = lnCnt_q;
    measWidth_d     = measWidth_q;
    measHeight_d    = measHeight_q;
    frameCnt_d      = frameCnt_q;
    errEarlyEol_d   = errEarlyEol_q;
    errLateEol_d    = errLateEol_q;
    errEarlySof_d   = errEarlySof_q;
    errMissingSof_d = errMissingSof_q;
    locked_d        = locked_q;
    cleanCnt_d      = cleanCnt_q;
    dirty_d         = dirty_q;
    startFrame      = 1'b0;
    countBeat       = 1'b0;
    newErr          = 1'b0;
    px              = pxCnt_q;
    ln              = lnCnt_q;

    if (clr_err_i) begin
      errEarlyEol_d   = 1'b0;
      errLateEol_d    = 1'b0;
      errEarlySof_d   = 1'b0;
      errMissingSof_d = 1'b0;
      locked_d        = 1'b0;
      cleanCnt_d      = 2'd0;
    end

    if (inBeat) begin
      case (state_q)
        WAIT_SOF: startFrame = video_i.tuser;
        IN_FRAME: begin
          countBeat = 1'b1;
          if (video_i.tuser && ((pxCnt_q | lnCnt_q) != '0)) begin
            errEarlySof_d = 1'b1;
            newErr        = 1'b1;
            startFrame    = 1'b1;
          end
        end
        EXPECT_SOF: begin
          measHeight_d = lnCnt_q;
          frameCnt_d   = frameCnt_q + 16'd1;
          if (video_i.tuser) begin
            startFrame = 1'b1;
            if (!dirty_q) begin
              if (cleanCnt_d == 2'd0) cleanCnt_d = 2'd1;
              else begin
                cleanCnt_d = 2'd2;
                locked_d   = 1'b1;
              end
            end
          end else begin
            errMissingSof_d = 1'b1;
            newErr          = 1'b1;
            state_d         = WAIT_SOF;
          end
        end
        default: state_d = WAIT_SOF;
      endcase

      // A SOF beat is counted as the first pixel of line 0 of the new frame
      if (startFrame) begin
        px        = '0;
        ln        = '0;
        countBeat = 1'b1;
        dirty_d   = 1'b0;
        state_d   = IN_FRAME;
      end

      if (countBeat) begin
        if (video_i.tlast) begin
          measWidth_d = (px == CntMax) ? px : px + 1'b1;
          if (px < XLast) begin
            errEarlyEol_d = 1'b1;
            newErr        = 1'b1;
          end
          pxCnt_d = '0;
          lnCnt_d = (ln == CntMax) ? ln : ln + 1'b1;
          if (ln == YLast) state_d = EXPECT_SOF;
        end else begin
          if (px == XLast) begin
            errLateEol_d = 1'b1;
            newErr       = 1'b1;
          end
          pxCnt_d = (px == CntMax) ? px : px + 1'b1;
          lnCnt_d = ln;
        end
      end

      if (newErr) begin
        locked_d   = 1'b0;
        cleanCnt_d = 2'd0;
        dirty_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= WAIT_SOF;
      pxCnt_q         <= '0;
      lnCnt_q         <= '0;
      measWidth_q     <= '0;
      measHeight_q    <= '0;
      frameCnt_q      <= '0;
      errEarlyEol_q   <= 1'b0;
      errLateEol_q    <= 1'b0;
      errEarlySof_q   <= 1'b0;
      errMissingSof_q <= 1'b0;
      locked_q        <= 1'b0;
      cleanCnt_q      <= 2'd0;
      dirty_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      pxCnt_q         <= pxCnt_d;
      lnCnt_q         <= lnCnt_d;
      measWidth_q     <= measWidth_d;
      measHeight_q    <= measHeight_d;
      frameCnt_q      <= frameCnt_d;
      errEarlyEol_q   <= errEarlyEol_d;
      errLateEol_q    <= errLateEol_d;
      errEarlySof_q   <= errEarlySof_d;
      errMissingSof_q <= errMissingSof_d;
      locked_q        <= locked_d;
      cleanCnt_q      <= cleanCnt_d;
      dirty_q         <= dirty_d;
    end
  end

  assign meas_width_o      = measWidth_q;
  assign meas_height_o     = measHeight_q;
  assign frame_cnt_o       = frameCnt_q;
  assign err_early_eol_o   = errEarlyEol_q;
  assign err_late_eol_o    = errLateEol_q;
  assign err_early_sof_o   = errEarlySof_q;
  assign err_missing_sof_o = errMissingSof_q;
  assign locked_o          = locked_q;

endmodule

// File: tb/tb_axi4_video_stream_monitor.sv
// Testbench for axi4_video_stream_monitor: scoreboarded pass-through checking,
// table-driven line/frame vectors and hand-written multi-cycle corner cases.
module tb_axi4_video_stream_monitor;

  localparam int DW = 32;
  localparam int XA = 8;
  localparam int YA = 4;
  localparam int CW = 12;
  localparam int NumVecs = 18;

  typedef struct {
    int            beats;
    int            sofBeat;
    logic [CW-1:0] expWidth;
    logic [CW-1:0] expHeight;
    logic [15:0]   expFrames;
    logic [3:0]    expErr;
    logic          expLocked;
    logic          clrAfter;
  } lineVec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_err;
  logic [CW-1:0] measWidth, measHeight;
  logic [15:0]   frameCnt;
  logic          errEarlyEol, errLateEol, errEarlySof, errMissingSof, locked;
  logic [3:0]    errVec;

  axi4_stream_if #(.DATA_WIDTH(DW)) vidIn ();
  axi4_stream_if #(.DATA_WIDTH(DW)) vidOut ();

  int            checks = 0;
  int            errors = 0;
  logic [DW+1:0] sbQueue [$];
  logic [DW-1:0] dataCtr = 32'h0000_1000;
  bit            randomSink = 1'b0;

  assign errVec = {errEarlyEol, errLateEol, errEarlySof, errMissingSof};

  axi4_video_stream_monitor #(
    .TDATA_WIDTH(DW),
    .X_ACTIVE   (XA),
    .Y_ACTIVE   (YA),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .video_i          (vidIn),
    .video_o          (vidOut),
    .clr_err_i        (clr_err),
    .meas_width_o     (measWidth),
    .meas_height_o    (measHeight),
    .frame_cnt_o      (frameCnt),
    .err_early_eol_o  (errEarlyEol),
    .err_late_eol_o   (errLateEol),
    .err_early_sof_o  (errEarlySof),
    .err_missing_sof_o(errMissingSof),
    .locked_o         (locked)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic lineVec_t mkVec(input int beats, input int sof, input int w, input int h,
                                     input int f, input logic [3:0] e, input logic l, input logic c);
    lineVec_t v;
    v.beats     = beats;
    v.sofBeat   = sof;
    v.expWidth  = CW'(w);
    v.expHeight = CW'(h);
    v.expFrames = 16'(f);
    v.expErr    = e;
    v.expLocked = l;
    v.clrAfter  = c;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted
  task automatic sendBeat(input logic last, input logic user);
    int waited = 0;
    bit done = 1'b0;
    vidIn.tdata  = dataCtr;
    vidIn.tlast  = last;
    vidIn.tuser  = user;
    vidIn.tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (vidIn.tready) begin
        sbQueue.push_back({dataCtr, last, user});
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          checks++;
          errors++;
          $display("[TB] FAIL in_accept_timeout: tready stuck at %0b, required 1", vidIn.tready);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    vidIn.tvalid = 1'b0;
    dataCtr++;
  endtask

  task automatic applyStimulus(input lineVec_t v);
    for (int b = 1; b <= v.beats; b++) sendBeat(b == v.beats, b == v.sofBeat);
  endtask

  task automatic sendLine(input int beats, input logic sof);
    for (int b = 1; b <= beats; b++) sendBeat(b == beats, sof && (b == 1));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_width"}, measWidth, 0);
    checkOutput({tag, "_height"}, measHeight, 0);
    checkOutput({tag, "_frames"}, frameCnt, 0);
    checkOutput({tag, "_errs"}, errVec, 0);
    checkOutput({tag, "_locked"}, locked, 0);
    checkOutput({tag, "_in_tready"}, vidIn.tready, 0);
    checkOutput({tag, "_out_tvalid"}, vidOut.tvalid, 0);
    checkOutput({tag, "_out_fields"}, {vidOut.tdata, vidOut.tlast, vidOut.tuser}, 0);
  endtask

  initial begin
    vidOut.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      vidOut.tready = randomSink ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output scoreboard, stall stability and input-ready occupancy model
  int            occ = 0;
  int            sinceReset = 0;
  bit            prevStall = 1'b0;
  logic [DW+1:0] prevBeat = '0;

  always @(negedge clk) begin : outMonitor
    logic [DW+1:0] outBeat;
    logic [DW+1:0] expBeat;
    if (!rst_n) begin
      occ        = 0;
      sinceReset = 0;
      prevStall  = 1'b0;
      sbQueue.delete();
    end else begin
      outBeat = {vidOut.tdata, vidOut.tlast, vidOut.tuser};
      if (sinceReset < 2) sinceReset++;
      else checkOutput("in_tready_vs_fill", vidIn.tready, (occ != 2));
      if (prevStall) begin
        checkOutput("stall_tvalid", vidOut.tvalid, 1);
        checkOutput("stall_fields", outBeat, prevBeat);
      end
      if (vidOut.tvalid && vidOut.tready) begin
        if (sbQueue.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL out_beat: got unexpected beat %0h, required none", outBeat);
        end else begin
          expBeat = sbQueue.pop_front();
          checkOutput("out_beat", outBeat, expBeat);
        end
      end
      if (vidIn.tvalid && vidIn.tready) occ++;
      if (vidOut.tvalid && vidOut.tready) occ--;
      prevStall = vidOut.tvalid && !vidOut.tready;
      prevBeat  = outBeat;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    lineVec_t vecs [NumVecs];
    int       drainWait;

    vecs[0]  = mkVec(8,  1, 8,  0, 0, 4'b0000, 1'b0, 1'b0);
    vecs[1]  = mkVec(8,  0, 8,  0, 0, 4'b0000, 1'b0, 1'b0);
    vecs[2]  = mkVec(8,  0, 8,  0, 0, 4'b0000, 1'b0, 1'b0);
    vecs[3]  = mkVec(8,  0, 8,  0, 0, 4'b0000, 1'b0, 1'b0);
    vecs[4]  = mkVec(8,  1, 8,  4, 1, 4'b0000, 1'b0, 1'b0);
    vecs[5]  = mkVec(8,  0, 8,  4, 1, 4'b0000, 1'b0, 1'b0);
    vecs[6]  = mkVec(8,  0, 8,  4, 1, 4'b0000, 1'b0, 1'b0);
    vecs[7]  = mkVec(8,  0, 8,  4, 1, 4'b0000, 1'b0, 1'b0);
    vecs[8]  = mkVec(8,  1, 8,  4, 2, 4'b0000, 1'b1, 1'b0);
    vecs[9]  = mkVec(8,  0, 8,  4, 2, 4'b0000, 1'b1, 1'b0);
    vecs[10] = mkVec(6,  0, 6,  4, 2, 4'b1000, 1'b0, 1'b0);
    vecs[11] = mkVec(8,  0, 8,  4, 2, 4'b1000, 1'b0, 1'b0);
    vecs[12] = mkVec(8,  1, 8,  4, 3, 4'b1000, 1'b0, 1'b1);
    vecs[13] = mkVec(10, 3, 8,  4, 3, 4'b0010, 1'b0, 1'b1);
    vecs[14] = mkVec(8,  0, 8,  4, 3, 4'b0000, 1'b0, 1'b0);
    vecs[15] = mkVec(8,  0, 8,  4, 3, 4'b0000, 1'b0, 1'b0);
    vecs[16] = mkVec(8,  0, 8,  4, 3, 4'b0000, 1'b0, 1'b0);
    vecs[17] = mkVec(8,  1, 8,  4, 4, 4'b0000, 1'b0, 1'b0);

    rst_n        = 1'b0;
    clr_err      = 1'b0;
    vidIn.tvalid = 1'b0;
    vidIn.tdata  = '0;
    vidIn.tlast  = 1'b0;
    vidIn.tuser  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("init");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NumVecs; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_width", i), measWidth, vecs[i].expWidth);
      checkOutput($sformatf("vec%0d_height", i), measHeight, vecs[i].expHeight);
      checkOutput($sformatf("vec%0d_frames", i), frameCnt, vecs[i].expFrames);
      checkOutput($sformatf("vec%0d_errs", i), errVec, vecs[i].expErr);
      checkOutput($sformatf("vec%0d_locked", i), locked, vecs[i].expLocked);
      if (vecs[i].clrAfter) begin
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        checkOutput($sformatf("vec%0d_clr_errs", i), errVec, 0);
        checkOutput($sformatf("vec%0d_clr_locked", i), locked, 0);
      end
    end

    $display("[TB] late end-of-line timing");
    for (int b = 1; b <= 10; b++) begin
      sendBeat(b == 10, 1'b0);
      if (b == 7) checkOutput("late_eol_beat7", errLateEol, 0);
      if (b == 8) checkOutput("late_eol_beat8", errLateEol, 1);
    end
    checkOutput("late_width", measWidth, 10);
    checkOutput("late_errs", errVec, 4'b0100);
    sendLine(8, 1'b0);
    sendLine(8, 1'b0);

    $display("[TB] missing start of frame");
    sendBeat(1'b0, 1'b0);
    checkOutput("missing_errs", errVec, 4'b0101);
    checkOutput("missing_height", measHeight, 4);
    checkOutput("missing_frames", frameCnt, 5);
    sendBeat(1'b1, 1'b0);
    checkOutput("wait_sof_ignored_width", measWidth, 8);
    checkOutput("wait_sof_ignored_errs", errVec, 4'b0101);

    $display("[TB] reset mid-frame");
    sendBeat(1'b0, 1'b1);
    sendBeat(1'b0, 1'b0);
    sendBeat(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] random output backpressure");
    randomSink = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < YA; l++) sendLine(XA, l == 0);
    end
    sendBeat(1'b0, 1'b1);
    checkOutput("bp_width", measWidth, 8);
    checkOutput("bp_height", measHeight, 4);
    checkOutput("bp_frames", frameCnt, 3);
    checkOutput("bp_errs", errVec, 0);
    checkOutput("bp_locked", locked, 1);
    drainWait = 0;
    while (sbQueue.size() != 0 && drainWait < 200) begin
      @(posedge clk);
      drainWait++;
    end
    #1;
    checkOutput("bp_drained", sbQueue.size(), 0);
    randomSink = 1'b0;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
